// File: rtl/bfly_net.sv
// Multistage butterfly interconnect. Routes NumIn initiator requests onto NumOut bank ports
// and returns bank read data to each initiator.
// Latency: request/grant path is combinational; the response (vld_o/rdata_o) follows RespLat
// cycles after the handshake.
// Backpressure: a request that loses any stage, or whose bank holds gnt_i low, sees gnt_o=0.
// It must be held by the initiator. Nothing is queued inside the network.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   rr_i                     external priority digits (used when ExtPrio=1)
//   req_i/gnt_o/add_i/wen_i/wdata_i   initiator request side
//   rdata_o/vld_o            initiator response side
//   req_o/gnt_i/wdata_o      bank request side
//   rdata_i                  bank read data (sampled RespLat cycles after handshake)
module bfly_net #(
  parameter int NumIn         = 8,
  parameter int NumOut        = 8,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32,
  parameter int RespLat       = 1,
  parameter int Radix         = 2,
  parameter bit WriteRespOn   = 1'b1,
  parameter bit ExtPrio       = 1'b0
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [$clog2(NumOut)-1:0]                   rr_i,
  input  logic [NumIn-1:0]                            req_i,
  output logic [NumIn-1:0]                            gnt_o,
  input  logic [NumIn-1:0][$clog2(NumOut)-1:0]        add_i,
  input  logic [NumIn-1:0]                            wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]          wdata_i,
  output logic [NumIn-1:0][RespDataWidth-1:0]         rdata_o,
  output logic [NumIn-1:0]                            vld_o,
  output logic [NumOut-1:0]                           req_o,
  input  logic [NumOut-1:0]                           gnt_i,
  output logic [NumOut-1:0][ReqDataWidth-1:0]         wdata_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0]        rdata_i
);

  localparam int L      = $clog2(NumOut);
  localparam int DW     = $clog2(Radix);
  localparam int NS     = (L + DW - 1) / DW;
  localparam int Stride = NumOut / NumIn;

  // Lowest bank-index bit of the digit routed by stage s. The final stage may be
  // narrower than DW when L is not a multiple of the digit width.
  function automatic int stage_lsb(input int s);
    int v;
    v = L - (s + 1) * DW;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int stage_rs(input int s);
    return 1 << (L - s * DW - stage_lsb(s));
  endfunction

  // Per-stage link state. Index 0 is the network input, index NS the bank side.
  // Wire index w at stage s: the digit field of w selects the switch port, the other
  // bits select the switch. Each stage overwrites its digit with the target's digit,
  // so after the last stage the wire index equals the bank index.
  logic [NS:0][NumOut-1:0]                    st_req;
  logic [NS:0][NumOut-1:0][L-1:0]             st_bank;
  logic [NS:0][NumOut-1:0][ReqDataWidth-1:0]  st_data;
  logic [NS:0][NumOut-1:0][L-1:0]             st_src;   // originating network input

  logic [NS-1:0][NumOut-1:0][DW-1:0]          win_k;    // winning switch port per output
  logic [NS-1:0][NumOut-1:0][DW-1:0]          ptr_q, ptr_d;

  always_comb begin
    int   lsb, rs, p, start, k, wi, b;
    logic found;
    lsb     = 0;
    rs      = 1;
    p       = 0;
    start   = 0;
    k       = 0;
    wi      = 0;
    b       = 0;
    found   = 1'b0;
    st_req  = '0;
    st_bank = '0;
    st_data = '0;
    st_src  = '0;
    win_k   = '0;
    ptr_d   = ptr_q;
    gnt_o   = '0;

    for (int w = 0; w < NumOut; w++) begin
      st_src[0][w] = L'(w);
    end
    // Spread initiators evenly over the network inputs; the gaps carry req=0.
    for (int j = 0; j < NumIn; j++) begin
      st_req[0][j*Stride]  = req_i[j];
      st_bank[0][j*Stride] = add_i[j];
      st_data[0][j*Stride] = wdata_i[j];
    end

    // Forward pass: every switch output picks one matching input, starting from its
    // priority pointer and wrapping around the switch ports.
    for (int s = 0; s < NS; s++) begin
      lsb = stage_lsb(s);
      rs  = stage_rs(s);
      for (int o = 0; o < NumOut; o++) begin
        p     = (o >> lsb) & (rs - 1);
        start = ExtPrio ? ((int'(rr_i) >> lsb) & (rs - 1)) : int'(ptr_q[s][o]);
        found = 1'b0;
        for (int n = 0; n < Radix; n++) begin
          k  = (start + n) % rs;
          wi = (o & ~((rs - 1) << lsb)) | (k << lsb);
          if (!found && (n < rs) && st_req[s][wi] &&
              (((int'(st_bank[s][wi]) >> lsb) & (rs - 1)) == p)) begin
            found              = 1'b1;
            st_req[s+1][o]     = 1'b1;
            st_bank[s+1][o]    = st_bank[s][wi];
            st_data[s+1][o]    = st_data[s][wi];
            st_src[s+1][o]     = st_src[s][wi];
            win_k[s][o]        = DW'(k);
          end
        end
      end
    end

    // A request is granted when it is the one that reached its bank and the bank accepts.
    for (int j = 0; j < NumIn; j++) begin
      b        = int'(add_i[j]);
      gnt_o[j] = req_i[j] & st_req[NS][b] & gnt_i[b] & (st_src[NS][b] == L'(j * Stride));
    end

    // Round-robin pointers move past the winner only when that winner completed
    // its handshake at the bank, so a stalled winner keeps its priority.
    if (!ExtPrio) begin
      for (int s = 0; s < NS; s++) begin
        rs = stage_rs(s);
        for (int o = 0; o < NumOut; o++) begin
          if (st_req[s+1][o]) begin
            b = int'(st_bank[s+1][o]);
            if (st_req[NS][b] && gnt_i[b] && (st_src[NS][b] == st_src[s+1][o])) begin
              ptr_d[s][o] = DW'((int'(win_k[s][o]) + 1) % rs);
            end
          end
        end
      end
    end
  end

  assign req_o   = st_req[NS];
  assign wdata_o = st_data[NS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Response tracking: one RespLat-deep {valid, bank} shift register per initiator.
  logic [NumIn-1:0]                        push_vld;
  logic [RespLat-1:0][NumIn-1:0]           pipe_vld_q;
  logic [RespLat-1:0][NumIn-1:0][L-1:0]    pipe_bank_q;

  always_comb begin
    push_vld = '0;
    rdata_o  = '0;
    for (int j = 0; j < NumIn; j++) begin
      push_vld[j] = req_i[j] & gnt_o[j] & (~wen_i[j] | WriteRespOn);
      rdata_o[j]  = rdata_i[pipe_bank_q[RespLat-1][j]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q  <= '0;
      pipe_bank_q <= '0;
    end else begin
      pipe_vld_q[0]  <= push_vld;
      pipe_bank_q[0] <= add_i;
      for (int i = 1; i < RespLat; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_bank_q[i] <= pipe_bank_q[i-1];
      end
    end
  end

  assign vld_o = pipe_vld_q[RespLat-1];

endmodule

// File: tb/tb_bfly_net.sv
module tb_bfly_net;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 8-bank group shared by duts A (default), B (no write resp), C (RespLat=3)
  logic [2:0]        rr8;
  logic [7:0]        req8, wen8, gnt8;
  logic [7:0][2:0]   add8;
  logic [7:0][31:0]  wdata8, rdata8;
  logic [7:0]        gntA, vldA, reqoA, gntB, vldB, reqoB, gntC, vldC, reqoC;
  logic [7:0][31:0]  rdA, wdoA, rdB, wdoB, rdC, wdoC;

  // 16-bank group: dut D (radix 2), dut E (radix 4)
  logic [3:0]        rr16;
  logic [15:0]       req16, wen16, gnt16;
  logic [15:0][3:0]  add16;
  logic [15:0][31:0] wdata16, rdata16;
  logic [15:0]       gntD, vldD, reqoD, gntE, vldE, reqoE;
  logic [15:0][31:0] rdD, wdoD, rdE, wdoE;

  // dut F: 4 initiators, 8 banks, radix 4, external priority (shares bank side of group 8)
  logic [3:0]        req4, wen4;
  logic [3:0][2:0]   add4;
  logic [3:0][31:0]  wdata4;
  logic [3:0]        gntF, vldF;
  logic [3:0][31:0]  rdF;
  logic [7:0]        reqoF;
  logic [7:0][31:0]  wdoF;

  bfly_net dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr8), .req_i(req8), .gnt_o(gntA), .add_i(add8),
    .wen_i(wen8), .wdata_i(wdata8), .rdata_o(rdA), .vld_o(vldA), .req_o(reqoA),
    .gnt_i(gnt8), .wdata_o(wdoA), .rdata_i(rdata8));

  bfly_net #(.WriteRespOn(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr8), .req_i(req8), .gnt_o(gntB), .add_i(add8),
    .wen_i(wen8), .wdata_i(wdata8), .rdata_o(rdB), .vld_o(vldB), .req_o(reqoB),
    .gnt_i(gnt8), .wdata_o(wdoB), .rdata_i(rdata8));

  bfly_net #(.RespLat(3)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr8), .req_i(req8), .gnt_o(gntC), .add_i(add8),
    .wen_i(wen8), .wdata_i(wdata8), .rdata_o(rdC), .vld_o(vldC), .req_o(reqoC),
    .gnt_i(gnt8), .wdata_o(wdoC), .rdata_i(rdata8));

  bfly_net #(.NumIn(16), .NumOut(16), .Radix(2)) dut_d (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr16), .req_i(req16), .gnt_o(gntD), .add_i(add16),
    .wen_i(wen16), .wdata_i(wdata16), .rdata_o(rdD), .vld_o(vldD), .req_o(reqoD),
    .gnt_i(gnt16), .wdata_o(wdoD), .rdata_i(rdata16));

  bfly_net #(.NumIn(16), .NumOut(16), .Radix(4)) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr16), .req_i(req16), .gnt_o(gntE), .add_i(add16),
    .wen_i(wen16), .wdata_i(wdata16), .rdata_o(rdE), .vld_o(vldE), .req_o(reqoE),
    .gnt_i(gnt16), .wdata_o(wdoE), .rdata_i(rdata16));

  bfly_net #(.NumIn(4), .NumOut(8), .Radix(4), .ExtPrio(1'b1)) dut_f (
    .clk_i(clk), .rst_ni(rst_n), .rr_i(rr8), .req_i(req4), .gnt_o(gntF), .add_i(add4),
    .wen_i(wen4), .wdata_i(wdata4), .rdata_o(rdF), .vld_o(vldF), .req_o(reqoF),
    .gnt_i(gnt8), .wdata_o(wdoF), .rdata_i(rdata8));

  task automatic clear_inputs();
    rr8 = '0; req8 = '0; wen8 = '0; gnt8 = 8'hFF; add8 = '0; wdata8 = '0;
    rr16 = '0; req16 = '0; wen16 = '0; gnt16 = 16'hFFFF; add16 = '0; wdata16 = '0;
    req4 = '0; wen4 = '0; add4 = '0; wdata4 = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    req8 = 8'h08; add8[3] = 3'd5;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (reqoA !== 8'h20) begin n_fail++; $display("FAIL rst_req_o: got %h expected %h", reqoA, 8'h20); end
    n_checks++; if (gntA !== 8'h08) begin n_fail++; $display("FAIL rst_gnt_o: got %h expected %h", gntA, 8'h08); end
    n_checks++; if (vldA !== 8'h00) begin n_fail++; $display("FAIL rst_vld_o: got %h expected %h", vldA, 8'h00); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (vldA !== 8'h00) begin n_fail++; $display("FAIL rst_release_vld: got %h expected %h", vldA, 8'h00); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    clear_inputs();
    req8 = 8'h08; add8[3] = 3'd5; wdata8[3] = 32'hA5;
    #1;
    n_checks++; if (reqoA !== 8'h20) begin n_fail++; $display("FAIL basic_req_o: got %h expected %h", reqoA, 8'h20); end
    n_checks++; if (wdoA[5] !== 32'hA5) begin n_fail++; $display("FAIL basic_wdata_o: got %h expected %h", wdoA[5], 32'hA5); end
    n_checks++; if (gntA !== 8'h08) begin n_fail++; $display("FAIL basic_gnt_o: got %h expected %h", gntA, 8'h08); end
    @(negedge clk);
    clear_inputs();
    rdata8[5] = 32'h1234;
    #1;
    n_checks++; if (vldA !== 8'h08) begin n_fail++; $display("FAIL basic_vld_o: got %h expected %h", vldA, 8'h08); end
    n_checks++; if (rdA[3] !== 32'h1234) begin n_fail++; $display("FAIL basic_rdata_o: got %h expected %h", rdA[3], 32'h1234); end
    n_checks++; if (vldB !== 8'h08) begin n_fail++; $display("FAIL basic_read_nowresp_vld: got %h expected %h", vldB, 8'h08); end
    @(negedge clk);
    rdata8[5] = 32'hB005;
    #1;
    n_checks++; if (vldA !== 8'h00) begin n_fail++; $display("FAIL basic_vld_drop: got %h expected %h", vldA, 8'h00); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    clear_inputs();
    req8 = 8'h03; add8[0] = 3'd2; add8[1] = 3'd2;
    #1;
    n_checks++; if (gntA !== 8'h01) begin n_fail++; $display("FAIL cont_gnt_c1: got %h expected %h", gntA, 8'h01); end
    n_checks++; if (reqoA !== 8'h04) begin n_fail++; $display("FAIL cont_req_o: got %h expected %h", reqoA, 8'h04); end
    @(negedge clk);
    #1;
    n_checks++; if (gntA !== 8'h02) begin n_fail++; $display("FAIL cont_gnt_c2: got %h expected %h", gntA, 8'h02); end
    n_checks++; if (vldA !== 8'h01) begin n_fail++; $display("FAIL cont_vld_c2: got %h expected %h", vldA, 8'h01); end
    n_checks++; if (rdA[0] !== 32'hB002) begin n_fail++; $display("FAIL cont_rdata0: got %h expected %h", rdA[0], 32'hB002); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++; if (vldA !== 8'h02) begin n_fail++; $display("FAIL cont_vld_c3: got %h expected %h", vldA, 8'h02); end
    n_checks++; if (rdA[1] !== 32'hB002) begin n_fail++; $display("FAIL cont_rdata1: got %h expected %h", rdA[1], 32'hB002); end
  endtask

  task automatic test_write();
    @(negedge clk);
    clear_inputs();
    req8 = 8'h04; add8[2] = 3'd7; wen8 = 8'h04; wdata8[2] = 32'h77;
    #1;
    n_checks++; if (gntA !== 8'h04) begin n_fail++; $display("FAIL wr_gnt_a: got %h expected %h", gntA, 8'h04); end
    n_checks++; if (gntB !== 8'h04) begin n_fail++; $display("FAIL wr_gnt_b: got %h expected %h", gntB, 8'h04); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++; if (vldA !== 8'h04) begin n_fail++; $display("FAIL wr_vld_resp_on: got %h expected %h", vldA, 8'h04); end
    n_checks++; if (vldB !== 8'h00) begin n_fail++; $display("FAIL wr_vld_resp_off: got %h expected %h", vldB, 8'h00); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    clear_inputs();
    gnt8 = 8'hEF; req8 = 8'h01; add8[0] = 3'd4;
    #1;
    n_checks++; if (reqoA !== 8'h10) begin n_fail++; $display("FAIL stall_req_o: got %h expected %h", reqoA, 8'h10); end
    n_checks++; if (gntA !== 8'h00) begin n_fail++; $display("FAIL stall_gnt_o: got %h expected %h", gntA, 8'h00); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++; if (vldA !== 8'h00) begin n_fail++; $display("FAIL stall_vld_o: got %h expected %h", vldA, 8'h00); end
  endtask

  // Inputs 0 and 4 share the first-stage link towards banks 0..3.
  task automatic test_blocking();
    logic [7:0] exp_req;
    @(negedge clk);
    clear_inputs();
    req8 = 8'h11; add8[0] = 3'd0; add8[4] = 3'd1;
    #1;
    n_checks++; if (gntA !== 8'h01 && gntA !== 8'h10) begin n_fail++; $display("FAIL block_gnt_one: got %h expected %h or %h", gntA, 8'h01, 8'h10); end
    exp_req = (gntA == 8'h01) ? 8'h01 : 8'h02;
    n_checks++; if (reqoA !== exp_req) begin n_fail++; $display("FAIL block_req_o: got %h expected %h", reqoA, exp_req); end
  endtask

  task automatic test_latency();
    logic [7:0]  exp_v;
    logic [31:0] exp_d;
    idle(4);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c < 3) begin req8 = 8'h02; add8[1] = 3'(c); end
      #1;
      exp_v = (c >= 3 && c <= 5) ? 8'h02 : 8'h00;
      n_checks++; if (vldC !== exp_v) begin n_fail++; $display("FAIL lat3_vld_c%0d: got %h expected %h", c, vldC, exp_v); end
      if (c >= 3 && c <= 5) begin
        exp_d = 32'hB000 + 32'(c - 3);
        n_checks++; if (rdC[1] !== exp_d) begin n_fail++; $display("FAIL lat3_rdata_c%0d: got %h expected %h", c, rdC[1], exp_d); end
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    clear_inputs();
    req8 = 8'h02; add8[1] = 3'd3;
    #1;
    n_checks++; if (gntC !== 8'h02) begin n_fail++; $display("FAIL midrst_gnt: got %h expected %h", gntC, 8'h02); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 2; c < 6; c++) begin
      #1;
      n_checks++; if (vldC !== 8'h00) begin n_fail++; $display("FAIL midrst_vld_c%0d: got %h expected %h", c, vldC, 8'h00); end
      @(negedge clk);
    end
  endtask

  task automatic test_identity();
    @(negedge clk);
    clear_inputs();
    req16 = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      add16[i]   = 4'(i);
      wdata16[i] = 32'h100 + 32'(i);
      rdata16[i] = 32'hD00 + 32'(i);
    end
    #1;
    n_checks++; if (gntD !== 16'hFFFF) begin n_fail++; $display("FAIL ident_r2_gnt: got %h expected %h", gntD, 16'hFFFF); end
    n_checks++; if (gntE !== 16'hFFFF) begin n_fail++; $display("FAIL ident_r4_gnt: got %h expected %h", gntE, 16'hFFFF); end
    n_checks++; if (reqoE !== 16'hFFFF) begin n_fail++; $display("FAIL ident_r4_req: got %h expected %h", reqoE, 16'hFFFF); end
    n_checks++; if (wdoE !== wdata16) begin n_fail++; $display("FAIL ident_r4_wdata: got %h expected %h", wdoE, wdata16); end
    n_checks++; if (wdoD !== wdata16) begin n_fail++; $display("FAIL ident_r2_wdata: got %h expected %h", wdoD, wdata16); end
    @(negedge clk);
    req16 = '0;
    #1;
    n_checks++; if (vldD !== 16'hFFFF) begin n_fail++; $display("FAIL ident_r2_vld: got %h expected %h", vldD, 16'hFFFF); end
    n_checks++; if (rdE !== rdata16) begin n_fail++; $display("FAIL ident_r4_rdata: got %h expected %h", rdE, rdata16); end
  endtask

  // Initiators 0 and 1 sit on network inputs 0 and 2 and collide in the first radix-4 stage.
  task automatic test_extprio();
    @(negedge clk);
    clear_inputs();
    req4 = 4'b0011; add4[0] = 3'd6; add4[1] = 3'd6; wdata4[0] = 32'hAA; wdata4[1] = 32'hBB;
    rr8 = 3'b000;
    #1;
    n_checks++; if (gntF !== 4'b0001) begin n_fail++; $display("FAIL ext_rr0_gnt: got %h expected %h", gntF, 4'b0001); end
    n_checks++; if (reqoF !== 8'h40) begin n_fail++; $display("FAIL ext_req_o: got %h expected %h", reqoF, 8'h40); end
    n_checks++; if (wdoF[6] !== 32'hAA) begin n_fail++; $display("FAIL ext_rr0_wdata: got %h expected %h", wdoF[6], 32'hAA); end
    rr8 = 3'b010;
    #1;
    n_checks++; if (gntF !== 4'b0010) begin n_fail++; $display("FAIL ext_rr2_gnt: got %h expected %h", gntF, 4'b0010); end
    n_checks++; if (wdoF[6] !== 32'hBB) begin n_fail++; $display("FAIL ext_rr2_wdata: got %h expected %h", wdoF[6], 32'hBB); end
    rr8 = 3'b100;
    #1;
    n_checks++; if (gntF !== 4'b0001) begin n_fail++; $display("FAIL ext_rr4_gnt: got %h expected %h", gntF, 4'b0001); end
    @(negedge clk);
    clear_inputs();
    req4 = 4'b1000; add4[3] = 3'd1;
    #1;
    n_checks++; if (gntF !== 4'b1000) begin n_fail++; $display("FAIL sparse_gnt: got %h expected %h", gntF, 4'b1000); end
    n_checks++; if (reqoF !== 8'h02) begin n_fail++; $display("FAIL sparse_req_o: got %h expected %h", reqoF, 8'h02); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++; if (vldF !== 4'b1000) begin n_fail++; $display("FAIL sparse_vld: got %h expected %h", vldF, 4'b1000); end
    n_checks++; if (rdF[3] !== 32'hB001) begin n_fail++; $display("FAIL sparse_rdata: got %h expected %h", rdF[3], 32'hB001); end
  endtask

  initial begin
    clear_inputs();
    rdata16 = '0;
    for (int b = 0; b < 8; b++) rdata8[b] = 32'hB000 + 32'(b);
    test_reset();
    test_basic();
    test_contention();
    test_write();
    test_stall();
    test_blocking();
    test_latency();
    test_mid_reset();
    test_identity();
    test_extprio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bfly_net.md
BFLY_NET -- requirements
Module: bfly_net

Interface
REQ-001 SHALL have parameter NumIn, default 8: number of initiator ports; power of 2, NumIn <= NumOut.
REQ-002 SHALL have parameter NumOut, default 8: number of bank ports; power of 2, >= 2.
REQ-003 SHALL have parameter ReqDataWidth, default 32: width of the request payload routed to banks.
REQ-004 SHALL have parameter RespDataWidth, default 32: width of the read data.
REQ-005 SHALL have parameter RespLat, default 1: bank read latency in cycles, >= 1.
REQ-006 SHALL have parameter Radix, default 2: switch radix, 2 or 4.
REQ-007 SHALL have parameter WriteRespOn, default 1: 1 means writes also produce vld_o.
REQ-008 SHALL have parameter ExtPrio, default 0: 1 means arbitration priority comes from rr_i, 0 means internal round-robin.
REQ-009 SHALL use one clock and an asynchronous active-low reset: clk_i (input, 1, clock) and rst_ni (input, 1, async active-low reset).
REQ-010 rr_i  input  $clog2(NumOut)  external priority; used only when ExtPrio=1.
REQ-011 req_i  input  NumIn  request per initiator.
REQ-012 gnt_o  output  NumIn  grant per initiator.
REQ-013 add_i  input  NumIn x $clog2(NumOut)  target bank index.
REQ-014 wen_i  input  NumIn  1 = write, 0 = read.
REQ-015 wdata_i  input  NumIn x ReqDataWidth  request payload.
REQ-016 rdata_o  output  NumIn x RespDataWidth  response data.
REQ-017 vld_o  output  NumIn  response valid.
REQ-018 req_o  output  NumOut  request per bank.
REQ-019 gnt_i  input  NumOut  bank grant.
REQ-020 wdata_o  output  NumOut x ReqDataWidth  payload per bank.
REQ-021 rdata_i  input  NumOut x RespDataWidth  bank read data.

Function
REQ-022 The network SHALL be a multistage butterfly of Radix x Radix switches: L=$clog2(NumOut), stages=ceil(L/log2(Radix)); when Radix=4 and L is odd, the last stage SHALL use radix 2.
REQ-023 The network SHALL be built NumOut wide; when NumIn < NumOut, initiator j SHALL drive network input j*(NumOut/NumIn), and unused inputs SHALL be tied to req=0.
REQ-024 Stage s SHALL route on bank-index digit s counted from the MSB (log2(Radix) bits per digit).
REQ-025 Each switch output SHALL select one request among the switch inputs whose digit matches, and SHALL forward req and wdata combinationally.
REQ-026 Priority, ExtPrio=1: search SHALL start at the input index equal to the rr_i bits of digit s.
REQ-027 Priority, ExtPrio=0: each switch output SHALL keep its own round-robin pointer, which advances past the winner only on a downstream handshake.
REQ-028 gnt_o[j] SHALL be combinational: asserted iff the request won every stage on its path and gnt_i of the target bank is 1; gnt_o=0 whenever req_i=0.
REQ-029 req_o[k]=1 iff some request reaches bank k, independent of gnt_i[k]; wdata_o[k] SHALL be that request's payload and is don't-care when req_o[k]=0.
REQ-030 Path blocking is allowed: two requests to different banks that share an internal link SHALL have at most one granted per cycle.
REQ-031 Response tracking: on handshake (req_i & gnt_o) with wen_i=0, or with wen_i=1 and WriteRespOn=1, SHALL push {1, add_i} into a per-initiator RespLat-deep shift register; otherwise SHALL push {0, x}.
REQ-032 vld_o[j] SHALL equal the valid bit delayed by exactly RespLat cycles, and rdata_o[j] SHALL equal rdata_i[delayed bank index].
REQ-033 Back-to-back handshakes every cycle SHALL produce back-to-back vld_o pulses in order.

Reset
REQ-034 While rst_ni=0, all response shift registers SHALL clear (vld_o=0) and all round-robin pointers SHALL reset to 0; combinational req_o/gnt_o SHALL follow the inputs.
REQ-035 Reset asserted mid-transaction SHALL drop pending responses without generating vld_o.

Verification
REQ-036 Defaults, req_i[3]=1, add_i[3]=5, wen_i=0, wdata_i[3]=0xA5, gnt_i=all 1 -> req_o=0x20, wdata_o[5]=0xA5, gnt_o=0x08 same cycle; with rdata_i[5]=0x1234 next cycle -> vld_o[3]=1, rdata_o[3]=0x1234.
REQ-037 Inputs 0 and 1 both target bank 2, ExtPrio=0, held for 2 cycles -> exactly one granted per cycle, alternating winners.
REQ-038 Write from input 2 to bank 7 with WriteRespOn=1 -> vld_o[2]=1 after RespLat; with WriteRespOn=0 -> vld_o stays 0.
REQ-039 gnt_i[4]=0 with one request to bank 4 -> req_o[4]=1, gnt_o=0, no vld_o.
REQ-040 RespLat=3, reads on 3 consecutive cycles -> three vld_o pulses on cycles 3, 4 and 5 with matching rdata.
REQ-041 Identity permutation (input i to bank i) for Radix 2 and Radix 4 with NumIn=NumOut=16 -> all inputs granted in the same cycle.
